// File: rtl/ustc_psum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ustc_psum_ctrl
// Brief    : Sequencer for the M x N partial-sum cache. It accepts tile beats,
//            steps the column index, fires the drain and counts drain beats.
// Revision : 1.0 - initial release
// ============================================================================
module ustc_psum_ctrl #(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int DW_COL = 4,
    parameter int DW_KT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DW_KT-1:0]  cfg_k_tiles,
    input  logic              tile_valid,
    output logic              tile_ready,
    output logic              psum_clr,
    output logic              psum_in_en,
    output logic [DW_COL-1:0] col,
    output logic              out_en,
    input  logic              out_valid,
    output logic [7:0]        drain_row,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_SETTLE = 3'd3,
        S_FIRE   = 3'd4,
        S_DRAIN  = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam logic [DW_COL-1:0] C_COL_LAST = DW_COL'(N - 1);
    localparam logic [7:0]        C_ROWS     = 8'(M);

    state_t             r_state;
    state_t             w_next;
    logic [DW_KT-1:0]   r_kt;
    logic [DW_KT-1:0]   r_tile_cnt;
    logic [DW_COL-1:0]  r_col;
    logic [7:0]         r_drain_row;

    logic               w_xfer;
    logic               w_col_end;
    logic               w_last_beat;
    logic               w_drain_last;

    // All strobes decode from the state register so reset clears them at once.
    assign tile_ready = (r_state == S_ACCUM);
    assign psum_clr   = (r_state == S_CLEAR);
    assign out_en     = (r_state == S_FIRE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH) && !out_valid && !abort;
    assign psum_in_en = w_xfer;
    assign col        = r_col;
    assign drain_row  = r_drain_row;

    assign w_xfer       = tile_valid & tile_ready;
    assign w_col_end    = w_xfer && (r_tile_cnt == (r_kt - DW_KT'(1)));
    assign w_last_beat  = w_col_end && (r_col == C_COL_LAST);
    assign w_drain_last = (r_state == S_DRAIN) && out_valid &&
                          (r_drain_row == (C_ROWS - 8'd1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_ACCUM;
            S_ACCUM:  if (w_last_beat) w_next = S_SETTLE;
            S_SETTLE: w_next = S_FIRE;
            S_FIRE:   w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_last) w_next = S_FINISH;
            S_FINISH: if (!out_valid) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kt        <= DW_KT'(1);
            r_tile_cnt  <= '0;
            r_col       <= '0;
            r_drain_row <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_kt <= (cfg_k_tiles == '0) ? DW_KT'(1) : cfg_k_tiles;
            end
            if (r_state == S_CLEAR) begin
                r_tile_cnt  <= '0;
                r_col       <= '0;
                r_drain_row <= '0;
            end
            // The final column holds at N-1 rather than wrapping.
            if (w_xfer) begin
                if (w_col_end) begin
                    r_tile_cnt <= '0;
                    if (r_col != C_COL_LAST) begin
                        r_col <= r_col + DW_COL'(1);
                    end
                end else begin
                    r_tile_cnt <= r_tile_cnt + DW_KT'(1);
                end
            end
            if ((r_state == S_DRAIN) && out_valid && (r_drain_row != C_ROWS)) begin
                r_drain_row <= r_drain_row + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ustc_psum_ctrl.md
Name: ustc_psum_ctrl

Overview:
Sequencer for the partial-sum accumulator array (M x N cache, one output column per accumulation phase).
- Accepts tile beats from the upstream sparse-tile producer through a valid/ready handshake.
- Drives the column index and the accumulate qualifier, then triggers and tracks the row-by-row drain.
- Reports completion of one output block. Sits between the tile scheduler and the psum datapath.

Parameters:
M, 16, rows of the psum cache; also the number of drain beats expected (T_OUT)
N, 16, columns of the psum cache; accumulation phases per block
DW_COL, 4, width of the column index; must satisfy 2^DW_COL >= N
DW_KT, 8, width of the per-column tile-count config and counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin one output block; sampled only in IDLE
abort  in  1  cancel current block; return to IDLE
cfg_k_tiles  in  DW_KT  tile beats per column; latched on accepted start; 0 treated as 1
tile_valid  in  1  upstream beat available
tile_ready  out  1  controller accepts beat
psum_clr  out  1  one-cycle clear pulse to the accumulator cache
psum_in_en  out  1  accumulate qualifier, equal to tile_valid & tile_ready
col  out  DW_COL  current accumulation column
out_en  out  1  one-cycle drain trigger to the datapath
out_valid  in  1  datapath drain-beat strobe
drain_row  out  8  number of drain beats counted so far
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at block completion

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: col=0, drain_row=0, tile_ready=0, psum_clr=0, out_en=0, done=0, busy=0.
  - All counters are cleared.
  - Reset release is synchronous to clk.
- States: IDLE, CLEAR, ACCUM, SETTLE, FIRE, DRAIN, FINISH.
- IDLE:
  - start=1 -> CLEAR next cycle.
  - The latched tile count kt = max(cfg_k_tiles, 1).
  - start is ignored in every other state.
- CLEAR:
  - psum_clr=1 for exactly this cycle.
  - col and the tile counter are set to 0; drain_row is set to 0.
  - Next state is ACCUM.
- ACCUM:
  - tile_ready=1. A beat transfers when tile_valid & tile_ready.
  - psum_in_en is combinational and high in the transfer cycle.
  - On each transfer the tile counter increments.
  - When the transfer is the kt-th beat of a column, the tile counter wraps to 0 and col increments.
  - If that column was N-1, col stays N-1 and the next state is SETTLE.
  - No beat is accepted after the final beat: tile_ready=0 from the following cycle.
- SETTLE:
  - One idle cycle so the last accumulate write lands in the cache.
  - tile_ready=0. Next state is FIRE.
- FIRE:
  - out_en=1 for exactly one cycle. Next state is DRAIN.
- DRAIN:
  - Each cycle with out_valid=1 increments drain_row.
  - When drain_row reaches M, the next state is FINISH. drain_row saturates at M.
- FINISH:
  - Extra out_valid beats are ignored.
  - Stay in FINISH until out_valid=0, i.e. the datapath has returned to input mode.
  - In that cycle done=1 for exactly one cycle, and the next state is IDLE.
- abort=1 in any state other than IDLE:
  - Next state is IDLE, and done is not asserted.
  - A beat offered in the abort cycle is still accepted; psum_in_en reflects it.
  - abort has priority over every other transition.
- Width rules:
  - Counters never wrap past their terminal values.
  - col never exceeds N-1.
  - drain_row is 8 bits; M must be ≤ 255.
- Throughput:
  - With tile_valid held high, ACCUM lasts exactly N*kt cycles.
  - The block lasts N*kt + M + 5 cycles plus datapath drain latency.

Test Plan:
- Reset mid-ACCUM (col=5): drop rst asynchronously -> all outputs 0 immediately, state IDLE; start after release -> psum_clr pulse in the next cycle.
- Nominal block, N=16, cfg_k_tiles=4, tile_valid held high -> 64 psum_in_en pulses; col steps 0..15 every 4 beats; out_en pulses 2 cycles after the last beat.
- cfg_k_tiles=0 -> treated as 1: col increments on every beat, 16 beats total.
- Backpressure: tile_valid toggling 1,0,1,0 -> psum_in_en only on valid cycles; col and counters are unchanged on idle cycles; the total is still 64 beats.
- Drain: model out_valid high for M+1=17 cycles after out_en -> drain_row saturates at 16; done pulses once, in the cycle out_valid first returns to 0; busy falls the cycle after.
- abort during DRAIN (drain_row=7) -> IDLE next cycle with no done pulse; a new start with cfg_k_tiles=2 runs cleanly (32 beats).
